spmv_mem_req_arbiter: RTL
=========================

Name: spmv_mem_req_arbiter

Overview:
- Parametrised N-channel memory request arbiter and response router for the SpMV processing element.
- Replaces the fixed three-source (mac/cache/decoder) priority pop and memory request FIFO.
- Adds a selectable round-robin mode, channel-ID tag insertion, a bounded store-address pointer with drop counting, and response demultiplexing by tag.
- Sits between PE-internal request sources and the Convey memory port.

Parameters:
NUM_CH, 4, number of request channels; CH_W = clog2(NUM_CH), minimum 1
ADDR_W, 48, memory address width
DATA_W, 64, store data / load tag width
TAG_W, 2, per-channel user tag bits carried on loads
Q_DEPTH, 16, output request queue depth; power of 2, at least 4
RR, 1, 1 = round-robin, 0 = fixed priority with channel 0 highest

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_valid  in  NUM_CH  request present, one bit per channel
ch_ready  out  NUM_CH  one-hot grant (combinational)
ch_st  in  NUM_CH  1 = store, 0 = load
ch_use_ptr  in  NUM_CH  store takes its address from the internal store pointer
ch_addr  in  NUM_CH*ADDR_W  request address, channel k at [k*ADDR_W +: ADDR_W]
ch_d_or_tag  in  NUM_CH*DATA_W  store data, or load user tag in bits [TAG_W-1:0]
st_base_ld  in  1  load the store pointer and store end registers
st_base  in  ADDR_W  new store pointer value
st_end  in  ADDR_W  store end address (exclusive)
req_mem_ld  out  1  load request strobe
req_mem_st  out  1  store request strobe
req_mem_addr  out  ADDR_W  request address
req_mem_d_or_tag  out  DATA_W  store data, or load tag
req_mem_stall  in  1  memory port back-pressure
rsp_mem_push  in  1  load response valid
rsp_mem_tag  in  TAG_W+CH_W  response tag
rsp_mem_q  in  DATA_W  response data
rsp_push  out  NUM_CH  per-channel response strobe
rsp_q  out  DATA_W  routed response data
rsp_tag  out  TAG_W  routed user tag
st_drop_cnt  out  16  count of dropped stores, saturating
idle  out  1  no request held anywhere in the block

Behaviour:
- Reset (async, rst_n=0):
  - All strobes 0; req_mem_addr, req_mem_d_or_tag, rsp_q and rsp_tag are 0.
  - Queue emptied; staging register invalid; RR pointer 0.
  - Store pointer and store end are 0; st_drop_cnt 0; idle 1.
  - Reset mid-operation discards all queued and staged requests.
- Grant:
  - Eligible = ch_valid & {NUM_CH{~full_guard}}, where full_guard = (queue_count + staged) >= Q_DEPTH-2.
  - The guard leaves headroom for one staged entry plus one cycle of registered-stall latency, so the queue never overflows.
  - RR=0: lowest-index eligible channel wins.
  - RR=1: search starts at rr_ptr; after a grant to channel k, rr_ptr = (k+1) mod NUM_CH. rr_ptr holds when there is no grant.
  - A transfer occurs when ch_valid[k] and ch_ready[k] are both 1.
- Staging (the registered accept cycle):
  - Load: d_or_tag = zero-extended {user_tag[TAG_W-1:0], k[CH_W-1:0]}.
  - Store with ch_use_ptr=0: ch_addr is used as given.
  - Store with ch_use_ptr=1: address = st_ptr.
    - If st_ptr != st_end, st_ptr += 8 (modulo 2^ADDR_W) and the store is issued.
    - If st_ptr == st_end, the store is accepted but not enqueued, and st_drop_cnt increments (saturates at 0xFFFF).
  - st_base_ld the same cycle as a pointer-store accept: that store uses the old st_ptr; next st_ptr = st_base; st_end updated.
- Queue and output:
  - stall_r = req_mem_stall registered. Pop when queue not empty and stall_r=0.
  - Output registers load the popped entry. Strobes are 1 for exactly one cycle per popped entry, else 0.
  - Latency from accept (cycle T) to req_mem_* strobe is cycle T+2 when the queue is empty and stall_r=0.
  - Order is preserved within the queue.
- Response:
  - Registered; rsp_push[c]=1 at T+1 for rsp_mem_push at T, with c = rsp_mem_tag[CH_W-1:0].
  - rsp_tag = rsp_mem_tag[TAG_W+CH_W-1:CH_W]; rsp_q = rsp_mem_q.
  - If c >= NUM_CH the response is discarded and no rsp_push bit is set.
  - There is no response back-pressure; consumers must accept every strobe.
- idle: queue empty, no staged entry, and ch_valid == 0.

Test Plan:
- Reset then single load on ch2, addr 0x1000, user tag 1 -> one req_mem_ld at T+2 with addr 0x1000 and d_or_tag 0x6 ({01,10}); idle returns to 1.
- RR=1, all 4 channels valid continuously for 8 grants -> ch_ready sequence 0,1,2,3,0,1,2,3. RR=0 same stimulus -> ch0 granted every cycle.
- Pointer store: st_base_ld base 0x100, end 0x110, then 3 ch0 stores -> addresses 0x100 and 0x108 issued; third dropped; st_drop_cnt = 1.
- Hold req_mem_stall=1 for 40 cycles with all channels valid -> ch_ready drops at count 14; no entry lost; after release exactly 14 strobes, in order.
- rsp_mem_push with tag {2'b11, 2'd3}, data 0xDEAD -> rsp_push = 4'b1000 next cycle, rsp_tag 3, rsp_q 0xDEAD. NUM_CH=3 with tag channel 3 -> no push.
- Assert rst_n low mid-burst with 5 queued -> strobes 0 immediately; after release no stale request issues and idle = 1.

Source files
------------

// File: rtl/spmv_mem_req_arbiter.sv
// rtl/spmv_mem_req_arbiter.sv - N-channel memory request arbiter with store pointer and response router
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ch_valid/ch_ready     per-channel request handshake (ready is a combinational one-hot grant)
//   ch_st, ch_use_ptr     per-channel store flag and "take address from store pointer" flag
//   ch_addr, ch_d_or_tag  per-channel address and store data / load user tag (packed by channel)
//   st_base_ld/base/end   load the store pointer and its exclusive end address
//   req_mem_*             registered request to the memory port, req_mem_stall back-pressure
//   rsp_mem_*             load response from memory, routed to rsp_push/rsp_q/rsp_tag
//   st_drop_cnt           saturating count of pointer stores dropped at the end address
//   idle                  nothing queued, staged or requested
module spmv_mem_req_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 48,
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 2,
    parameter int Q_DEPTH = 16,
    parameter int RR      = 1,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH-1:0]        ch_st,
    input  logic [NUM_CH-1:0]        ch_use_ptr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_d_or_tag,
    input  logic                     st_base_ld,
    input  logic [ADDR_W-1:0]        st_base,
    input  logic [ADDR_W-1:0]        st_end,
    output logic                     req_mem_ld,
    output logic                     req_mem_st,
    output logic [ADDR_W-1:0]        req_mem_addr,
    output logic [DATA_W-1:0]        req_mem_d_or_tag,
    input  logic                     req_mem_stall,
    input  logic                     rsp_mem_push,
    input  logic [TAG_W+CH_W-1:0]    rsp_mem_tag,
    input  logic [DATA_W-1:0]        rsp_mem_q,
    output logic [NUM_CH-1:0]        rsp_push,
    output logic [DATA_W-1:0]        rsp_q,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [15:0]              st_drop_cnt,
    output logic                     idle
);
    localparam int QAW   = $clog2(Q_DEPTH);
    localparam int CNT_W = QAW + 1;
    localparam int EW    = 1 + ADDR_W + DATA_W;

    logic [NUM_CH-1:0] eligible, grant;
    logic [CH_W-1:0]   rr_ptr, grant_idx;
    logic              grant_any;
    logic              g_st, g_use_ptr;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_d;

    logic              stall_r;
    logic              stg_valid, stg_st;
    logic [ADDR_W-1:0] stg_addr;
    logic [DATA_W-1:0] stg_d;
    logic [ADDR_W-1:0] st_ptr, st_end_r;

    logic [EW-1:0]     q_mem [Q_DEPTH];
    logic [QAW-1:0]    q_wr, q_rd;
    logic [CNT_W-1:0]  q_count, held;
    logic              full_guard, from_q, out_fire, q_push, q_pop;
    logic [EW-1:0]     stg_entry, out_entry;

    logic              ptr_store, st_drop;
    logic [ADDR_W-1:0] stage_addr;
    logic [DATA_W-1:0] stage_d;
    logic [CH_W-1:0]   rsp_ch;
    logic              rsp_ok;

    // Headroom of two: one staged entry plus one cycle where stall_r lags the port.
    assign held       = q_count + CNT_W'(stg_valid);
    assign full_guard = held >= CNT_W'(Q_DEPTH - 2);
    assign eligible   = ch_valid & {NUM_CH{~full_guard}};
    assign ch_ready   = grant;

    always_comb begin : arb
        int              idx;
        logic [CH_W-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (RR != 0) ? ((int'(rr_ptr) + i) % NUM_CH) : i;
            sel = CH_W'(idx);
            if (!grant_any && eligible[sel]) begin
                grant_any = 1'b1;
                grant[sel] = 1'b1;
                grant_idx = sel;
            end
        end
    end

    always_comb begin
        g_st      = 1'b0;
        g_use_ptr = 1'b0;
        g_addr    = '0;
        g_d       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                g_st      = ch_st[k];
                g_use_ptr = ch_use_ptr[k];
                g_addr    = ch_addr[k*ADDR_W +: ADDR_W];
                g_d       = ch_d_or_tag[k*DATA_W +: DATA_W];
            end
        end
    end

    // A pointer store at the end address is consumed but never reaches the queue.
    assign ptr_store  = grant_any & g_st & g_use_ptr;
    assign st_drop    = ptr_store & (st_ptr == st_end_r);
    assign stage_addr = ptr_store ? st_ptr : g_addr;
    assign stage_d    = g_st ? g_d : DATA_W'({g_d[TAG_W-1:0], grant_idx});

    // The staged entry bypasses the queue when the queue is empty, giving
    // accept-to-strobe latency of two cycles; otherwise it joins the tail.
    assign stg_entry = {stg_st, stg_addr, stg_d};
    assign from_q    = q_count != '0;
    assign out_fire  = ~stall_r & (from_q | stg_valid);
    assign q_push    = stg_valid & (from_q | stall_r);
    assign q_pop     = out_fire & from_q;
    assign out_entry = from_q ? q_mem[q_rd] : stg_entry;

    assign rsp_ch = rsp_mem_tag[CH_W-1:0];
    assign rsp_ok = rsp_mem_push && (int'(rsp_ch) < NUM_CH);

    assign idle = ~from_q & ~stg_valid & ~(|ch_valid);

    always_ff @(posedge clk) begin
        if (q_push) begin
            q_mem[q_wr] <= stg_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r          <= 1'b0;
            rr_ptr           <= '0;
            stg_valid        <= 1'b0;
            stg_st           <= 1'b0;
            stg_addr         <= '0;
            stg_d            <= '0;
            st_ptr           <= '0;
            st_end_r         <= '0;
            st_drop_cnt      <= '0;
            q_wr             <= '0;
            q_rd             <= '0;
            q_count          <= '0;
            req_mem_ld       <= 1'b0;
            req_mem_st       <= 1'b0;
            req_mem_addr     <= '0;
            req_mem_d_or_tag <= '0;
            rsp_push         <= '0;
            rsp_q            <= '0;
            rsp_tag          <= '0;
        end else begin
            stall_r <= req_mem_stall;

            if (grant_any && RR != 0) begin
                rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
            end

            stg_valid <= grant_any & ~st_drop;
            if (grant_any) begin
                stg_st   <= g_st;
                stg_addr <= stage_addr;
                stg_d    <= stage_d;
            end

            // A base load wins over the increment; a same-cycle store used the old pointer.
            if (st_base_ld) begin
                st_ptr   <= st_base;
                st_end_r <= st_end;
            end else if (ptr_store && !st_drop) begin
                st_ptr <= st_ptr + ADDR_W'(8);
            end
            if (st_drop && st_drop_cnt != 16'hFFFF) begin
                st_drop_cnt <= st_drop_cnt + 16'd1;
            end

            if (q_push) q_wr <= q_wr + QAW'(1);
            if (q_pop)  q_rd <= q_rd + QAW'(1);
            q_count <= q_count + CNT_W'(q_push) - CNT_W'(q_pop);

            req_mem_ld <= out_fire & ~out_entry[EW-1];
            req_mem_st <= out_fire & out_entry[EW-1];
            if (out_fire) begin
                req_mem_addr     <= out_entry[DATA_W +: ADDR_W];
                req_mem_d_or_tag <= out_entry[DATA_W-1:0];
            end

            rsp_push <= rsp_ok ? (NUM_CH'(1) << rsp_ch) : '0;
            if (rsp_ok) begin
                rsp_q   <= rsp_mem_q;
                rsp_tag <= rsp_mem_tag[TAG_W+CH_W-1:CH_W];
            end
        end
    end
endmodule
